mod_mul_seq: RTL and testbench

//   Bit-serial modular multiplier over the secp256k1 field: result = a*b mod P.

---
 rtl/mod_mul_seq.sv | 117 +++++++++++
 tb/tb_mod_mul_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mod_mul_seq.sv
// Bit-serial modular multiplier over the secp256k1 field.
// Computes result = a*b mod P, one multiplier bit per cycle, MSB first.
//
// Ports:
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset
//   start  : request, sampled only while idle
//   a      : multiplicand (any value, reduced once on capture)
//   b      : multiplier (any value, consumed MSB-first)
//   result : a*b mod P, held until next completion or reset
//   done   : one-cycle pulse, result valid in that cycle
//   busy   : high while an operation is in flight
module mod_mul_seq #(
  parameter int W = 256,
  parameter logic [W-1:0] P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         done,
  output logic         busy
);

  localparam int IW = $clog2(W);
  localparam logic [W:0] PX = {1'b0, P};

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state, state_nxt;

  logic [W-1:0]  ar;
  logic [W-1:0]  br;
  logic [W-1:0]  acc;
  logic [IW-1:0] idx;

  logic [W-1:0]  a_red;
  logic [W:0]    dbl;
  logic [W-1:0]  dbl_red;
  logic [W-1:0]  addend;
  logic [W:0]    sum;
  logic [W-1:0]  acc_nxt;
  logic          last;
  logic          accept;
  logic          step;

  assign accept = (state == IDLE) && start;
  assign step   = (state == RUN);
  assign last   = (idx == '0);

  // 2P > 2^W, so one conditional subtract fully reduces any W-bit input.
  always_comb begin
    a_red = a;
    if (a >= P) a_red = a - P;
  end

  // Double-and-add step; acc < P keeps every intermediate below 2P.
  always_comb begin
    dbl     = {acc, 1'b0};
    dbl_red = dbl[W-1:0];
    if (dbl >= PX) dbl_red = W'(dbl - PX);
    addend  = br[idx] ? ar : '0;
    sum     = {1'b0, dbl_red} + {1'b0, addend};
    acc_nxt = sum[W-1:0];
    if (sum >= PX) acc_nxt = W'(sum - PX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ar     <= '0;
      br     <= '0;
      acc    <= '0;
      idx    <= '0;
      result <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        ar   <= a_red;
        br   <= b;
        acc  <= '0;
        idx  <= IW'(W - 1);
        busy <= 1'b1;
      end else if (step) begin
        acc <= acc_nxt;
        idx <= idx - IW'(1);
        if (last) begin
          result <= acc_nxt;
          done   <= 1'b1;
          busy   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mod_mul_seq.sv
// Self-checking bench for mod_mul_seq.
// Directed vectors, handshake corner cases and random pairs vs a*b mod P.
module tb_mod_mul_seq;

  localparam int W = 256;
  localparam logic [W-1:0] P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam logic [W-1:0] HALF =
    256'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_7FFFFE18;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] result;
  logic         done;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  bit busy_bad;

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mod_mul_seq #(.W(W), .P(P)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .result (result),
    .done   (done),
    .busy   (busy)
  );

  function automatic logic [W-1:0] ref_mul(
    input logic [W-1:0] x,
    input logic [W-1:0] y
  );
    logic [2*W-1:0] xx, yy, pp, m;
    xx = {{W{1'b0}}, x};
    yy = {{W{1'b0}}, y};
    pp = {{W{1'b0}}, P};
    m  = (xx * yy) % pp;
    return m[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand256();
    logic [W-1:0] r;
    for (int k = 0; k < W / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(
    input string        name,
    input logic [W-1:0] got,
    input logic [W-1:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y);
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    busy_bad = 1'b0;
    while (!done && n < W + 20) begin
      if (!busy) busy_bad = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic finish_check(input string name, input logic [W-1:0] exp);
    wait_done();
    chk({name, "_result"}, result, exp);
    chk({name, "_latency"}, W'(cyc - acc_cyc), W'(W));
    chk({name, "_busy_run"}, W'(busy_bad), '0);
    chk({name, "_busy_done"}, W'(busy), '0);
  endtask

  task automatic run_check(
    input string        name,
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic [W-1:0] exp
  );
    launch(x, y);
    finish_check(name, exp);
  endtask

  initial begin
    int seen;
    logic [W-1:0] x, y;

    vecs[0] = '{"two_three", 256'd2, 256'd3, 256'd6};
    vecs[1] = '{"neg1_sq", P - 1, P - 1, 256'd1};
    vecs[2] = '{"inv_pair", 256'd2, HALF, 256'd1};
    vecs[3] = '{"unreduced", P + 5, 256'd1, 256'd5};
    vecs[4] = '{"zero_a", 256'd0, P - 1, 256'd0};
    vecs[5] = '{"neg1_two", P - 1, 256'd2, P - 2};

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    #2;
    chk("rst_result", result, '0);
    chk("rst_done", W'(done), '0);
    chk("rst_busy", W'(busy), '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++)
      run_check(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].exp);

    // start re-pulsed mid-run with new operands must be ignored
    launch(256'd7, 256'd9);
    repeat (50) @(posedge clk);
    #1;
    a = 256'd11;
    b = 256'd13;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    finish_check("midrun_start", 256'd63);

    // start held in the done cycle: back-to-back acceptance
    chk("b2b_done_seen", W'(done), W'(1));
    a = 256'd5;
    b = 256'd6;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    acc_cyc = cyc;
    chk("b2b_done_pulse", W'(done), '0);
    chk("b2b_busy", W'(busy), W'(1));
    finish_check("b2b", 256'd30);

    // asynchronous abort mid-run
    launch(256'd3, 256'd4);
    repeat (100) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_result", result, '0);
    chk("abort_done", W'(done), '0);
    chk("abort_busy", W'(busy), '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 0;
    repeat (W + 5) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    chk("abort_no_done", W'(seen), '0);
    run_check("fresh", 256'd12345, 256'd678, 256'd8369910);

    for (int i = 0; i < 200; i++) begin
      x = rand256();
      y = rand256();
      if (i % 8 == 0) x = P + W'($urandom_range(0, 1000));
      if (i % 16 == 1) y = '0;
      if (i % 16 == 3) y = P - W'($urandom_range(1, 50));
      run_check("random", x, y, ref_mul(x, y));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
